// File: rtl/uart_pkg.sv
// uart_pkg: shared UART datapath constants (data width, FIFO depth, control-block register offsets)
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam logic [31:0] UART_RX_DATA = 32'h3000_0000;
  localparam logic [31:0] UART_TX_DATA = 32'h3000_0004;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_W unreset register array; ports wb_clk_i, sync write (we, waddr, wdata), async read (raddr -> rdata)
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH = UART_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              wb_clk_i,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge wb_clk_i)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: FWFT sync FIFO; in wb_clk_i wb_rst_i push_i data_i pop_i flush_i clr_err_i thresh_i; out data_o cnt_o empty_o full_o ovf_o udf_o irq_o; irq_o built only with UART_FIFO_THRESH_IRQ_EN
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              flush_i,
  input  logic              clr_err_i,
  input  logic [CNT_W-1:0]  thresh_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              ovf_o,
  output logic              udf_o,
  output logic              irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
  end
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty_o = wr_ptr == rd_ptr;
  assign full_o = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cnt_o = CNT_W'(wr_ptr - rd_ptr);
  assign do_push = push_i && (!full_o || pop_i) && !flush_i;
  assign do_pop = pop_i && !empty_o && !flush_i;
  always_ff @(posedge wb_clk_i) begin
    wr_ptr <= (wb_rst_i || flush_i) ? '0 : wr_ptr + (do_push ? PW'(1) : PW'(0));
    rd_ptr <= (wb_rst_i || flush_i) ? '0 : rd_ptr + (do_pop ? PW'(1) : PW'(0));
    ovf_o <= !wb_rst_i && ((push_i && full_o && !pop_i && !flush_i) || (ovf_o && !clr_err_i));
    udf_o <= !wb_rst_i && ((pop_i && empty_o && !flush_i) || (udf_o && !clr_err_i));
  end
`ifdef UART_FIFO_THRESH_IRQ_EN
  always_ff @(posedge wb_clk_i)
    irq_o <= !wb_rst_i && thresh_i != '0 && cnt_o >= thresh_i;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh_i;
  assign irq_o = 1'b0;
`endif
  uart_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .wb_clk_i(wb_clk_i),
    .we(do_push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(data_i),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(data_o)
  );
endmodule

// File: tb/tb_uart_sync_fifo.sv
// tb_uart_sync_fifo: randomized and directed checks of uart_sync_fifo (DEPTH=4) against a queue-based model
module tb_uart_sync_fifo;
  logic clk = 0, rst = 0, push = 0, pop = 0, flush = 0, clr = 0;
  logic [7:0] din = 0, dout;
  logic [2:0] th = 0, cnt;
  logic empty, full, ovf, udf, irq;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic m_ovf = 0, m_udf = 0, m_irq = 0;

  uart_sync_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .push_i(push), .data_i(din), .pop_i(pop),
    .data_o(dout), .flush_i(flush), .clr_err_i(clr), .thresh_i(th), .cnt_o(cnt),
    .empty_o(empty), .full_o(full), .ovf_o(ovf), .udf_o(udf), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic pu, input logic [7:0] d, input logic po, input logic fl, input logic cl);
    int n = q.size();
    push = pu; din = d; pop = po; flush = fl; clr = cl;
`ifdef UART_FIFO_THRESH_IRQ_EN
    m_irq = th != 0 && n >= int'(th);
`else
    m_irq = 0;
`endif
    m_ovf = (!fl && pu && n == 4 && !po) || (m_ovf && !cl);
    m_udf = (!fl && po && n == 0) || (m_udf && !cl);
    if (fl) q.delete();
    else begin
      if (po && n > 0) void'(q.pop_front());
      if (pu && (n < 4 || po)) q.push_back(d);
    end
    @(posedge clk); #1;
    push = 0; pop = 0; flush = 0; clr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete(); m_ovf = 0; m_udf = 0; m_irq = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b want 10", empty, full); end
    checks++; if ({ovf, udf, irq} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ovf, udf, irq}); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] v[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) cyc(1, v[i], 0, 0, 0);
    checks++; if (full !== 1'b1 || cnt !== 3'd4) begin errors++; $display("FAIL fill_full got full=%b cnt=%0d want 1/4", full, cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout !== v[i]) begin errors++; $display("FAIL drain_order[%0d] got %h want %h", i, dout, v[i]); end
      cyc(0, 0, 1, 0, 0);
    end
    checks++; if (empty !== 1'b1 || cnt !== 3'd0) begin errors++; $display("FAIL drain_empty got empty=%b cnt=%0d want 1/0", empty, cnt); end
  endtask

  task automatic test_overflow();
    logic [7:0] v[4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    cyc(1, 8'h11, 0, 0, 0); cyc(1, 8'h22, 0, 0, 0); cyc(1, 8'h33, 0, 0, 0); cyc(1, 8'h44, 0, 0, 0);
    cyc(1, 8'h55, 0, 0, 0);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
    checks++; if (cnt !== 3'd4 || dout !== 8'h11) begin errors++; $display("FAIL ovf_hold got cnt=%0d head=%h want 4/11", cnt, dout); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", ovf); end
    cyc(1, 8'h55, 1, 0, 0);
    checks++; if (cnt !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL full_pushpop got cnt=%0d ovf=%b want 4/0", cnt, ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout !== v[i]) begin errors++; $display("FAIL full_pushpop_order[%0d] got %h want %h", i, dout, v[i]); end
      cyc(0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_empty_pushpop();
    cyc(1, 8'hA5, 1, 0, 0);
    checks++; if (udf !== 1'b1 || cnt !== 3'd1 || dout !== 8'hA5) begin errors++; $display("FAIL empty_pushpop got udf=%b cnt=%0d data=%h want 1/1/a5", udf, cnt, dout); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (udf !== 1'b0 || cnt !== 3'd1) begin errors++; $display("FAIL udf_clr got udf=%b cnt=%0d want 0/1", udf, cnt); end
    cyc(0, 0, 1, 0, 1);
    checks++; if (udf !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL pop_last got udf=%b empty=%b want 0/1", udf, empty); end
    cyc(0, 0, 1, 0, 1);
    checks++; if (udf !== 1'b1) begin errors++; $display("FAIL udf_set_wins got %b want 1", udf); end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_wrap();
    int pi = 0;
    for (int i = 0; i < 7; i++) begin
      if (i >= 1) begin
        checks++; if (dout !== 8'h60 + 8'(pi)) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", pi, dout, 8'h60 + 8'(pi)); end
        pi++;
      end
      cyc(i < 6, 8'h60 + 8'(i), i >= 1, 0, 0);
      checks++; if (cnt > 3'd4 || int'(cnt) != q.size()) begin errors++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", i, cnt, q.size()); end
    end
    checks++; if (empty !== 1'b1 || udf !== 1'b0) begin errors++; $display("FAIL wrap_end got empty=%b udf=%b want 1/0", empty, udf); end
  endtask

  task automatic test_irq();
    do_reset();
    th = 3;
    for (int i = 0; i < 6; i++) begin
      cyc(i < 3, 8'(i), i == 4, 0, 0);
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL irq_step[%0d] got %b want %b", i, irq, m_irq); end
    end
`ifdef UART_FIFO_THRESH_IRQ_EN
    checks++; if (irq !== 1'b0 || cnt !== 3'd2) begin errors++; $display("FAIL irq_fall got irq=%b cnt=%0d want 0/2", irq, cnt); end
`else
    checks++; if (irq !== 1'b0 || cnt !== 3'd2) begin errors++; $display("FAIL irq_tied got irq=%b cnt=%0d want 0/2", irq, cnt); end
`endif
    th = 0;
  endtask

  task automatic test_flush();
    do_reset();
    cyc(1, 8'h01, 0, 0, 0); cyc(1, 8'h02, 0, 0, 0); cyc(1, 8'h03, 0, 0, 0);
    cyc(1, 8'h04, 0, 1, 0);
    checks++; if (cnt !== 3'd0 || empty !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL flush got cnt=%0d empty=%b ovf=%b want 0/1/0", cnt, empty, ovf); end
    cyc(1, 8'h05, 0, 0, 0); cyc(1, 8'h06, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    cyc(1, 8'h07, 0, 0, 0); cyc(1, 8'h08, 0, 0, 0);
    checks++; if (udf !== 1'b1 || cnt !== 3'd2) begin errors++; $display("FAIL pre_reset got udf=%b cnt=%0d want 1/2", udf, cnt); end
    do_reset();
    checks++; if (cnt !== 3'd0 || empty !== 1'b1 || {ovf, udf, irq, full} !== 4'b0000) begin errors++; $display("FAIL mid_reset got cnt=%0d empty=%b flags=%b want 0/1/0000", cnt, empty, {ovf, udf, irq, full}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) th = 3'($urandom_range(0, 4));
      cyc($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0);
      checks++; if (int'(cnt) != q.size() || empty !== (q.size() == 0) || full !== (q.size() == 4)) begin errors++; $display("FAIL rand_cnt[%0d] got cnt=%0d e=%b f=%b want %0d", i, cnt, empty, full, q.size()); end
      checks++; if (ovf !== m_ovf || udf !== m_udf || irq !== m_irq) begin errors++; $display("FAIL rand_flags[%0d] got %b%b%b want %b%b%b", i, ovf, udf, irq, m_ovf, m_udf, m_irq); end
      if (q.size() > 0) begin
        checks++; if (dout !== q[0]) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", i, dout, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_empty_pushpop();
    test_wrap();
    test_irq();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_sync_fifo.md
# uart_sync_fifo

Parametrised synchronous FIFO for the UART datapath. It replaces the fixed 4-entry byte FIFO between the Wishbone control block and the UART receive/transmit engines. The design keeps one instance on the RX side (push from the receiver, pop on CPU read) and one on the TX side (push on CPU write, pop on transmit start). Additions over the previous generation:
- configurable width and depth
- exact full/empty/count with no lost entry
- defined simultaneous push/pop behaviour
- flush
- sticky overflow/underflow flags
- an optional fill-level interrupt

## Interface
Parameters:
- DATA_W, default 8: entry width in bits.
- DEPTH, default 16: number of entries. Must be a power of two, ≥ 2.
- CNT_W, default $clog2(DEPTH)+1: width of the count and threshold fields.

Ports:
- wb_clk_i  in  1  Single clock. All state changes on its rising edge.
- wb_rst_i  in  1  Reset. Synchronous and active-high.
- push_i  in  1  Write data_i this cycle.
- data_i  in  DATA_W  Write data.
- pop_i  in  1  Consume the head entry this cycle.
- data_o  out  DATA_W  Head entry, first-word-fall-through.
- flush_i  in  1  Discard all entries.
- clr_err_i  in  1  Clear the sticky error flags.
- thresh_i  in  CNT_W  Interrupt fill threshold.
- cnt_o  out  CNT_W  Current occupancy, 0..DEPTH.
- empty_o  out  1  cnt_o == 0.
- full_o  out  1  cnt_o == DEPTH.
- ovf_o  out  1  Sticky overflow flag.
- udf_o  out  1  Sticky underflow flag.
- irq_o  out  1  Level interrupt.

## Operation
- Pointers:
  - wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - cnt_o = wr_ptr − rd_ptr, modulo 2^CNT_W.
- Push accepted: push_i && (!full_o || pop_i). mem[wr_ptr] ← data_i, then wr_ptr increments.
- Pop accepted: pop_i && !empty_o. rd_ptr increments.
- Full with push and pop together: both are accepted and the count is unchanged.
- Empty with push and pop together:
  - The push is accepted and the pop is ignored.
  - udf_o is set.
  - The new entry appears on data_o on the next cycle.
- Rejected push (full, no pop): data is dropped, ovf_o is set, and memory and pointers are unchanged.
- Rejected pop (empty): udf_o is set, and pointers are unchanged.
- flush_i:
  - Both pointers are set to 0.
  - Overrides push_i and pop_i in the same cycle.
  - Does not set the error flags.
- ovf_o and udf_o:
  - Once set, they hold until clr_err_i or reset.
  - If clr_err_i coincides with a new error event, the flag remains set (set wins).
- data_o:
  - Combinational read of mem[rd_ptr].
  - Undefined (do-not-care) while empty_o = 1.
- Pointer wrap: addresses wrap modulo DEPTH through natural overflow of the low bits. There is no explicit comparison against DEPTH.

## Timing
- Reset values:
  - Pointers 0.
  - cnt_o = 0, empty_o = 1, full_o = 0.
  - ovf_o = 0, udf_o = 0, irq_o = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation: all entries are discarded on that edge, identical to a flush plus clr_err.
- Latency:
  - A pushed word is visible on data_o and counted in cnt_o/empty_o/full_o one cycle after the push edge.
  - After a pop edge, data_o shows the next entry in the same cycle.
- empty_o, full_o and cnt_o are derived combinationally from the registered pointers. They have no extra delay beyond the pointers.
- ovf_o and udf_o are registered and rise on the edge that sees the offending request.
- irq_o is registered. It follows the condition (cnt ≥ thresh_i && thresh_i ≠ 0), evaluated on the current pointers, one cycle later.
- thresh_i may change at any time. The change takes effect on the next edge.

## Configuration
- Macro: UART_FIFO_THRESH_IRQ_EN.
- Defined:
  - irq_o is implemented as specified in Timing.
  - thresh_i is used.
- Undefined:
  - irq_o is tied to 0.
  - thresh_i is unused, and no threshold comparator or irq register is built.
  - All other behaviour is identical.

## Structure
- Shared package uart_pkg holds:
  - UART_DATA_W = 8
  - UART_FIFO_DEPTH = 16
  - the register-offset constants used by the UART control block (RX_DATA 0x3000_0000, TX_DATA 0x3000_0004)
- Sub-module uart_fifo_mem:
  - DEPTH × DATA_W register array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset on the array.
- Top-level uart_sync_fifo contains:
  - the pointers
  - the flags
  - the count/irq logic
  - a generate check that rejects a non-power-of-two DEPTH

## Test plan
All scenarios use DATA_W=8, DEPTH=4.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles → full_o=1 and cnt_o=4. Then four pops → data_o reads 0x11, 0x22, 0x33, 0x44 in order, and empty_o=1 after the last pop.
- Full FIFO, push 0x55 alone → ovf_o=1, cnt_o stays 4, head stays 0x11. Full FIFO, push 0x55 with pop together → cnt_o=4, and 0x55 is the last entry read out.
- Empty FIFO, push 0xA5 with pop together → udf_o=1, cnt_o=1, data_o=0xA5 next cycle. Then clr_err_i → udf_o=0.
- Six pushes and six pops interleaved to force pointer wrap → data is returned in order, and cnt_o never exceeds 4.
- With UART_FIFO_THRESH_IRQ_EN and thresh_i=3 → irq_o rises one cycle after the third push and falls one cycle after the pop that brings cnt_o to 2. Without the macro → irq_o stays 0 throughout.
- Push three entries, then flush_i asserted together with push_i → cnt_o=0, empty_o=1, ovf_o=0. Asserting wb_rst_i with two entries held → same result, and all flags are 0.
